// File: rtl/uart_tx_packer.sv
// uart_tx_packer: serialises CH_NUM x SAMPLE_W sample frames (MSB first) and one-byte status event codes for uart_tx.
// Define UART_TX_PACKER_CHKSUM_EN to append an XOR checksum byte to every sample frame.
module uart_tx_packer #(
  parameter int CH_NUM      = 2,
  parameter int SAMPLE_W    = 12,
  parameter int EVT_NUM     = 4,
  parameter int FRAME_LIMIT = 20000,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [EVT_NUM-1:0]         evt_in,
  input  logic                       stream_en,
  input  logic                       frame_clr,
  input  logic                       smp_valid,
  input  logic [CH_NUM*SAMPLE_W-1:0] smp_data,
  output logic                       smp_ready,
  input  logic                       uart_tx_busy,
  output logic                       uart_tx_en,
  output logic [7:0]                 uart_tx_data,
  output logic                       frame_done,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic                       limit_reached
);

  localparam int DW    = CH_NUM * SAMPLE_W;
  localparam int NDATA = (DW + 7) / 8;
`ifdef UART_TX_PACKER_CHKSUM_EN
  localparam int NBYTES = NDATA + 1;
`else
  localparam int NBYTES = NDATA;
`endif
  localparam int FW = NBYTES * 8;
  localparam int BW = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_IDLE} state_t;
  state_t state, state_next;

  logic [EVT_NUM-1:0] evt_q, pending, evt_rise, evt_clr, evt_pick, evt_sel;
  logic [7:0]         evt_code, tx_data;
  logic               evt_found, is_evt, accept, last_byte;
  logic [FW-1:0]      frame_in, frame_q;
  logic [BW-1:0]      byte_idx, byte_last;
  logic [CNT_W-1:0]   cnt_base, cnt_next;
  logic               cnt_inc, limit_hit;
`ifdef UART_TX_PACKER_CHKSUM_EN
  logic [7:0]         chk;
`endif

  assign evt_rise     = evt_in & ~evt_q;
  assign evt_clr      = (state == STROBE && is_evt) ? evt_sel : '0;
  assign uart_tx_data = tx_data;

  // Left-justify the sample word; the checksum (if any) occupies the last byte slot.
  always_comb begin
    frame_in = FW'(smp_data) << (FW - DW);
`ifdef UART_TX_PACKER_CHKSUM_EN
    chk = '0;
    for (int unsigned i = 0; i < NDATA; i++) chk ^= frame_in[FW-1-8*i -: 8];
    frame_in[7:0] = chk;
`endif
  end

  always_comb begin
    evt_pick  = '0;
    evt_code  = '0;
    evt_found = 1'b0;
    for (int unsigned k = 0; k < EVT_NUM; k++) begin
      if (pending[k] && !evt_found) begin
        evt_found   = 1'b1;
        evt_pick[k] = 1'b1;
        evt_code    = 8'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    uart_tx_en = 1'b0;
    frame_done = 1'b0;
    last_byte  = (byte_idx == byte_last);
    smp_ready  = rst_n && (state == IDLE) && (pending == '0) && stream_en &&
                 !limit_reached && !uart_tx_busy;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_next = LOAD;
        end else if (smp_ready && smp_valid) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:      state_next = STROBE;
      STROBE: begin
        uart_tx_en = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: if (uart_tx_busy) state_next = WAIT_IDLE;
      WAIT_IDLE: begin
        if (!uart_tx_busy) begin
          if (last_byte) begin
            state_next = IDLE;
            frame_done = !is_evt;
          end else begin
            state_next = STROBE;
          end
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q     <= '0;
      pending   <= '0;
      evt_sel   <= '0;
      is_evt    <= 1'b0;
      frame_q   <= '0;
      tx_data   <= '0;
      byte_idx  <= '0;
      byte_last <= '0;
    end else begin
      evt_q   <= evt_in;
      pending <= (pending & ~evt_clr) | evt_rise;
      case (state)
        IDLE: begin
          if (pending != '0) begin
            frame_q   <= FW'(evt_code) << (FW - 8);
            is_evt    <= 1'b1;
            evt_sel   <= evt_pick;
            byte_idx  <= '0;
            byte_last <= BW'(1);
          end else if (accept) begin
            frame_q   <= frame_in;
            is_evt    <= 1'b0;
            evt_sel   <= '0;
            byte_idx  <= '0;
            byte_last <= BW'(NBYTES);
          end
        end
        LOAD: begin
          tx_data <= frame_q[FW-1 -: 8];
          frame_q <= frame_q << 8;
        end
        STROBE:    byte_idx <= byte_idx + 1'b1;
        WAIT_IDLE: begin
          if (!uart_tx_busy && !last_byte) begin
            tx_data <= frame_q[FW-1 -: 8];
            frame_q <= frame_q << 8;
          end
        end
        default: ;
      endcase
    end
  end

  // A clear coinciding with a frame completion still counts that frame.
  always_comb begin
    cnt_base  = frame_clr ? '0 : frame_cnt;
    cnt_inc   = frame_done && (cnt_base != '1);
    cnt_next  = cnt_base + CNT_W'(cnt_inc);
    limit_hit = (FRAME_LIMIT != 0) && frame_done && (32'(cnt_next) == 32'(FRAME_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt     <= '0;
      limit_reached <= 1'b0;
    end else begin
      frame_cnt     <= cnt_next;
      limit_reached <= (limit_reached && !frame_clr) || limit_hit;
    end
  end

endmodule

// File: tb/tb_uart_tx_packer.sv
// Self-checking bench for uart_tx_packer: table-driven frames, event/limit/reset sequences, byte scoreboard.
module tb_uart_tx_packer;

`ifdef UART_TX_PACKER_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  evt_in;
  logic        stream_en, frame_clr, smp_valid, smp_ready;
  logic [23:0] smp_data;
  logic        uart_tx_busy, uart_tx_en, frame_done, limit_reached;
  logic [7:0]  uart_tx_data;
  logic [15:0] frame_cnt;

  uart_tx_packer #(
    .CH_NUM(2), .SAMPLE_W(12), .EVT_NUM(4), .FRAME_LIMIT(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .stream_en(stream_en), .frame_clr(frame_clr),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .limit_reached(limit_reached)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  b0, b1, b2, ck;
  } vec_t;
  vec_t tbl[5];

  int checks = 0, errors = 0, done_seen = 0, bytes_seen = 0, busy_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // uart_tx model: busy for 10 cycles after each strobe
  initial begin
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy_cnt = 0;
        uart_tx_busy = 1'b0;
      end else if (uart_tx_en) begin
        busy_cnt = 10;
        uart_tx_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        uart_tx_busy = (busy_cnt != 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx_en) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_byte: got unexpected byte %0h, expected none", uart_tx_data);
        end else begin
          check("tx_byte", 32'(uart_tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (rst_n && frame_done) done_seen++;
    end
  end

  task automatic push_frame(input vec_t v);
    exp_q.push_back(v.b0);
    exp_q.push_back(v.b1);
    exp_q.push_back(v.b2);
    if (CHK) exp_q.push_back(v.ck);
  endtask

  task automatic send_sample(input vec_t v);
    int n = 0;
    smp_data  = v.data;
    smp_valid = 1'b1;
    while (!smp_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!smp_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: smp_ready got 0, expected 1");
    end else begin
      push_frame(v);
    end
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (20) tick();
  endtask

  task automatic pulse_clr();
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    tick();
  endtask

  task automatic wait_bytes(input int target, input string name);
    int n = 0;
    while (bytes_seen < target && n < 3000) begin
      tick();
      n++;
    end
    if (bytes_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d bytes, expected %0d", name, bytes_seen, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, n;
    logic ready_seen;
    tbl[0] = '{24'hABC123, 8'hAB, 8'hC1, 8'h23, 8'h49};
    tbl[1] = '{24'h000000, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{24'h123456, 8'h12, 8'h34, 8'h56, 8'h70};
    tbl[4] = '{24'h800001, 8'h80, 8'h00, 8'h01, 8'h81};

    rst_n = 1'b0; evt_in = '0; stream_en = 1'b1; frame_clr = 1'b0;
    smp_valid = 1'b0; smp_data = '0;
    repeat (3) tick();
    check("rst_tx_en", 32'(uart_tx_en), 0);
    check("rst_tx_data", 32'(uart_tx_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_limit", 32'(limit_reached), 0);
    check("rst_smp_ready", 32'(smp_ready), 0);
    rst_n = 1'b1;
    tick();
    check("idle_smp_ready", 32'(smp_ready), 1);

    // table-driven frames (includes the checksum vector)
    for (int i = 0; i < 5; i++) begin
      pulse_clr();
      d0 = done_seen;
      send_sample(tbl[i]);
      drain("frame");
      check("frame_cnt", 32'(frame_cnt), 1);
      check("frame_done_pulses", 32'(done_seen - d0), 1);
    end

    // two events rise together while idle
    d0 = done_seen;
    evt_in = 4'b0101;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    tick();
    evt_in = '0;
    drain("evt");
    check("evt_no_frame_done", 32'(done_seen - d0), 0);

    // event raised during byte 2 of a frame
    pulse_clr();
    d0 = done_seen;
    b0 = bytes_seen;
    send_sample(tbl[3]);
    wait_bytes(b0 + 2, "mid_frame");
    evt_in = 4'b0010;
    exp_q.push_back(8'h02);
    n = 0;
    while (done_seen == d0 && n < 3000) begin
      tick();
      n++;
    end
    tick();
    check("ready_while_evt_pending", 32'(smp_ready), 0);
    evt_in = '0;
    drain("mid_evt");
    check("mid_evt_frame_cnt", 32'(frame_cnt), 1);
    check("mid_evt_done_pulses", 32'(done_seen - d0), 1);

    // frame limit
    pulse_clr();
    check("clr_frame_cnt", 32'(frame_cnt), 0);
    for (int f = 0; f < 3; f++) send_sample(tbl[f]);
    drain("limit");
    check("limit_frame_cnt", 32'(frame_cnt), 3);
    check("limit_reached", 32'(limit_reached), 1);
    smp_valid = 1'b1;
    smp_data = tbl[4].data;
    ready_seen = 1'b0;
    repeat (30) begin
      tick();
      if (smp_ready) ready_seen = 1'b1;
    end
    check("ready_at_limit", 32'(ready_seen), 0);
    smp_valid = 1'b0;
    pulse_clr();
    check("limit_clr_cnt", 32'(frame_cnt), 0);
    check("limit_clr_flag", 32'(limit_reached), 0);
    send_sample(tbl[1]);
    drain("resume");
    check("resume_frame_cnt", 32'(frame_cnt), 1);

    // reset after the first byte of a frame
    b0 = bytes_seen;
    send_sample(tbl[0]);
    wait_bytes(b0 + 1, "pre_reset");
    rst_n = 1'b0;
    #1;
    check("midrst_tx_en", 32'(uart_tx_en), 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    check("midrst_smp_ready", 32'(smp_ready), 0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    d0 = done_seen;
    send_sample(tbl[0]);
    drain("post_reset");
    check("post_reset_frame_cnt", 32'(frame_cnt), 1);
    check("post_reset_done_pulses", 32'(done_seen - d0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
